// File: rtl/lamp_bus_arbiter_if.sv
// Lamp-card bus arbiter port bundle: two requesters plus the
// board/address/data/strobe pins of the shared parallel bus.
`timescale 1ns/1ps
interface lamp_bus_arbiter_if;
  logic [1:0]  req_valid;
  logic [1:0]  req_write;
  logic [7:0]  req_board;
  logic [5:0]  req_addr;
  logic [15:0] req_wdata;
  logic [1:0]  req_ready;
  logic [1:0]  req_done;
  logic [7:0]  rdata;
  logic [3:0]  BOARD_X;
  logic [2:0]  AddessPortPin;
  logic [7:0]  Data_Out_Port;
  logic [7:0]  Data_In_Port;
  logic        data_dir;
  logic        RdP;
  logic        WrP;
  logic        busy;

  modport master (
    output req_valid, req_write, req_board,
    output req_addr, req_wdata, Data_In_Port,
    input  req_ready, req_done, rdata,
    input  BOARD_X, AddessPortPin, Data_Out_Port,
    input  data_dir, RdP, WrP, busy
  );

  modport slave (
    input  req_valid, req_write, req_board,
    input  req_addr, req_wdata, Data_In_Port,
    output req_ready, req_done, rdata,
    output BOARD_X, AddessPortPin, Data_Out_Port,
    output data_dir, RdP, WrP, busy
  );
endinterface

// File: rtl/lamp_bus_arbiter.sv
// Two-port arbiter sequencing setup/strobe/hold cycles on the lamp bus.
// LAMP_BUS_FIXED_PRIORITY_EN: port 0 always wins ties (else round-robin).
`timescale 1ns/1ps
module lamp_bus_arbiter #(
  parameter int CLOCK_FREQUENCY = 27000000,
  parameter int SETUP_CYCLES    = 3,
  parameter int STROBE_CYCLES   = 6,
  parameter int HOLD_CYCLES     = 3
) (
  input logic               clock,
  input logic               reset_n,
  lamp_bus_arbiter_if.slave bus
);

  localparam int SE = (SETUP_CYCLES  < 1) ? 1 : SETUP_CYCLES;
  localparam int WE = (STROBE_CYCLES < 1) ? 1 : STROBE_CYCLES;
  localparam int HE = (HOLD_CYCLES   < 1) ? 1 : HOLD_CYCLES;
  localparam int M1 = (SE > WE) ? SE : WE;
  localparam int CMAX = (M1 > HE) ? M1 : HE;
  localparam int CW = $clog2(CMAX + 1)
                    + ((CLOCK_FREQUENCY > 0) ? 0 : 0);

  localparam logic [CW-1:0] S_LD = CW'(SE);
  localparam logic [CW-1:0] W_LD = CW'(WE);
  localparam logic [CW-1:0] H_LD = CW'(HE);
  localparam logic [CW-1:0] ONE  = CW'(1);

  typedef enum logic [1:0] {
    IDLE, SETUP, STROBE, HOLD
  } state_t;

  state_t          state_q;
  state_t          state_d;
  logic [CW-1:0]   cnt_q;
  logic [CW-1:0]   cnt_d;
  logic            grant;
  logic            owner_q;
  logic            wr_q;
  logic            wr_d;
  logic            start;
  logic            last_cyc;

`ifdef LAMP_BUS_FIXED_PRIORITY_EN
  assign grant = ~bus.req_valid[0];
`else
  logic last_grant;

  assign grant = (&bus.req_valid) ? ~last_grant
                                  : bus.req_valid[1];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      last_grant <= 1'b1;
    end else if (start) begin
      last_grant <= grant;
    end
  end
`endif

  assign start    = (state_q == IDLE) && (|bus.req_valid);
  assign last_cyc = (cnt_q == ONE);
  assign wr_d     = start ? bus.req_write[grant] : wr_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = SETUP;
          cnt_d   = S_LD;
        end
      end
      SETUP: begin
        if (last_cyc) begin
          state_d = STROBE;
          cnt_d   = W_LD;
        end else begin
          cnt_d = cnt_q - ONE;
        end
      end
      STROBE: begin
        if (last_cyc) begin
          state_d = HOLD;
          cnt_d   = H_LD;
        end else begin
          cnt_d = cnt_q - ONE;
        end
      end
      HOLD: begin
        if (last_cyc) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - ONE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Pins are registered from next-state so they move with the FSM.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      owner_q           <= 1'b0;
      wr_q              <= 1'b0;
      bus.req_ready     <= '0;
      bus.req_done      <= '0;
      bus.rdata         <= '0;
      bus.BOARD_X       <= '0;
      bus.AddessPortPin <= '0;
      bus.Data_Out_Port <= '0;
      bus.data_dir      <= 1'b0;
      bus.RdP           <= 1'b1;
      bus.WrP           <= 1'b1;
      bus.busy          <= 1'b0;
    end else begin
      bus.req_ready <= '0;
      bus.req_done  <= '0;
      if (start) begin
        owner_q       <= grant;
        wr_q          <= wr_d;
        bus.req_ready <= {grant, ~grant};
        bus.BOARD_X   <= grant ? bus.req_board[7:4]
                               : bus.req_board[3:0];
        bus.AddessPortPin <= grant ? bus.req_addr[5:3]
                                   : bus.req_addr[2:0];
        if (wr_d) begin
          bus.Data_Out_Port <= grant ? bus.req_wdata[15:8]
                                     : bus.req_wdata[7:0];
        end
      end
      if (state_q == STROBE && last_cyc && !wr_q) begin
        bus.rdata <= bus.Data_In_Port;
      end
      if (state_d == HOLD && cnt_d == ONE) begin
        bus.req_done <= {owner_q, ~owner_q};
      end
      bus.data_dir <= (state_d != IDLE) && wr_d;
      bus.RdP      <= !(state_d == STROBE && !wr_d);
      bus.WrP      <= !(state_d == STROBE && wr_d);
      bus.busy     <= (state_d != IDLE);
    end
  end

endmodule

// File: tb/tb_lamp_bus_arbiter.sv
// Directed bench for lamp_bus_arbiter: single transfers, tie arbitration,
// field isolation, mid-transfer reset and the zero-parameter instance.
`timescale 1ns/1ps
module tb_lamp_bus_arbiter;

  localparam int S = 3;
  localparam int W = 6;
  localparam int H = 3;

  logic clock = 1'b0;
  logic reset_n = 1'b0;

  always #5 clock = ~clock;

  lamp_bus_arbiter_if bus ();
  lamp_bus_arbiter_if busm ();

  lamp_bus_arbiter #(
    .CLOCK_FREQUENCY(27000000),
    .SETUP_CYCLES(S),
    .STROBE_CYCLES(W),
    .HOLD_CYCLES(H)
  ) dut (
    .clock(clock),
    .reset_n(reset_n),
    .bus(bus.slave)
  );

  lamp_bus_arbiter #(
    .CLOCK_FREQUENCY(27000000),
    .SETUP_CYCLES(0),
    .STROBE_CYCLES(0),
    .HOLD_CYCLES(0)
  ) dut_min (
    .clock(clock),
    .reset_n(reset_n),
    .bus(busm.slave)
  );

  typedef struct {
    int         port;
    bit         rd;
    logic [7:0] data;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] onehot(input int p);
    return (p == 1) ? 2'b10 : 2'b01;
  endfunction

  task automatic push_exp(input int p, input bit rd,
                          input logic [7:0] d);
    exp_t e;
    e.port = p;
    e.rd   = rd;
    e.data = d;
    sb.push_back(e);
  endtask

  task automatic pop_done(input logic [1:0] done,
                          input logic [7:0] rd);
    exp_t e;
    check("sb_has_entry", 32'(sb.size() > 0), 1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check("done_port", done, onehot(e.port));
      if (e.rd) check("rdata", rd, e.data);
    end
  endtask

  task automatic txn(input int p, input bit wr,
                     input logic [3:0] brd,
                     input logic [2:0] adr,
                     input logic [7:0] wd,
                     input logic [7:0] din,
                     input bit perturb);
    bus.req_valid = '0;
    bus.req_valid[p] = 1'b1;
    bus.req_write[p] = wr;
    bus.req_board[4*p +: 4] = brd;
    bus.req_addr[3*p +: 3]  = adr;
    bus.req_wdata[8*p +: 8] = wd;
    bus.Data_In_Port = 8'h11;
    push_exp(p, !wr, din);
    for (int k = 1; k <= S + W + H + 1; k++) begin
      @(negedge clock);
      check("ready", bus.req_ready,
            (k == 1) ? onehot(p) : 2'b00);
      if (k == 1) bus.req_valid = '0;
      check("wrp", bus.WrP,
            32'(!(wr && k >= S + 1 && k <= S + W)));
      check("rdp", bus.RdP,
            32'(!(!wr && k >= S + 1 && k <= S + W)));
      check("dir", bus.data_dir,
            32'(wr && k <= S + W + H));
      check("busy", bus.busy, 32'(k <= S + W + H));
      if (k <= S + W + H) begin
        check("board", bus.BOARD_X, brd);
        check("addr", bus.AddessPortPin, adr);
        if (wr) check("dout", bus.Data_Out_Port, wd);
      end
      if (k == S + W + H)
        pop_done(bus.req_done, bus.rdata);
      else
        check("done_quiet", bus.req_done, 2'b00);
      if (k == S + 1) bus.Data_In_Port = din;
      if (k == S + W + 1) bus.Data_In_Port = 8'h11;
      if (perturb && k == S + 2) begin
        bus.req_board = ~bus.req_board;
        bus.req_addr  = ~bus.req_addr;
        bus.req_wdata = ~bus.req_wdata;
      end
    end
  endtask

  initial begin
    int order [4];
    int g;
    int nd;
    int last_c;
    bit got;

    bus.req_valid = '0;
    bus.req_write = '0;
    bus.req_board = '0;
    bus.req_addr = '0;
    bus.req_wdata = '0;
    bus.Data_In_Port = '0;
    busm.req_valid = '0;
    busm.req_write = '0;
    busm.req_board = '0;
    busm.req_addr = '0;
    busm.req_wdata = '0;
    busm.Data_In_Port = '0;

    repeat (3) @(negedge clock);
    check("rst_rdp", bus.RdP, 1);
    check("rst_wrp", bus.WrP, 1);
    check("rst_dir", bus.data_dir, 0);
    check("rst_board", bus.BOARD_X, 0);
    check("rst_addr", bus.AddessPortPin, 0);
    check("rst_dout", bus.Data_Out_Port, 0);
    check("rst_rdata", bus.rdata, 0);
    check("rst_ready", bus.req_ready, 0);
    check("rst_done", bus.req_done, 0);
    check("rst_busy", bus.busy, 0);
    reset_n = 1'b1;
    @(negedge clock);

    txn(0, 1'b1, 4'h2, 3'h5, 8'hA5, 8'h00, 1'b0);
    txn(1, 1'b0, 4'h7, 3'h2, 8'h00, 8'h3C, 1'b0);
    check("rdata_held", bus.rdata, 8'h3C);
    txn(1, 1'b1, 4'h9, 3'h3, 8'h5A, 8'h00, 1'b1);

`ifdef LAMP_BUS_FIXED_PRIORITY_EN
    order = '{0, 0, 0, 0};
`else
    order = '{0, 1, 0, 1};
`endif
    bus.req_write = 2'b11;
    bus.req_board = 8'h84;
    bus.req_addr = 6'o61;
    bus.req_wdata = 16'hBEEF;
    for (int i = 0; i < 4; i++) push_exp(order[i], 1'b0, 8'h00);
    bus.req_valid = 2'b11;
    g = 0;
    nd = 0;
    last_c = 0;
    for (int c = 1; c <= 80; c++) begin
      @(negedge clock);
      if (bus.req_ready != 2'b00 && g < 4) begin
        check("tie_grant", bus.req_ready, onehot(order[g]));
        if (g > 0) check("tie_period", c - last_c, 13);
        last_c = c;
        g++;
        if (g == 4) bus.req_valid = '0;
      end
      if (bus.req_done != 2'b00) begin
        pop_done(bus.req_done, bus.rdata);
        nd++;
      end
      if (nd == 4) break;
    end
    check("tie_grants", g, 4);
    check("tie_dones", nd, 4);
    @(negedge clock);

    bus.req_write = 2'b01;
    bus.req_board = 8'h03;
    bus.req_addr = 6'o01;
    bus.req_wdata = 16'h00C3;
    bus.req_valid = 2'b01;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clock);
      if (k == 1) check("rst_txn_ready", bus.req_ready, 2'b01);
      check("rst_txn_done", bus.req_done, 2'b00);
    end
    check("pre_rst_wrp", bus.WrP, 0);
    reset_n = 1'b0;
    #1;
    check("async_wrp", bus.WrP, 1);
    check("async_dir", bus.data_dir, 0);
    check("async_busy", bus.busy, 0);
    repeat (2) begin
      @(negedge clock);
      check("rst_no_done", bus.req_done, 2'b00);
    end
    reset_n = 1'b1;
    push_exp(0, 1'b0, 8'h00);
    got = 1'b0;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clock);
      if (bus.req_ready != 2'b00) begin
        check("reissue_ready", bus.req_ready, 2'b01);
        check("reissue_latency", i, 1);
        bus.req_valid = '0;
        got = 1'b1;
      end
      if (bus.req_done != 2'b00) begin
        pop_done(bus.req_done, bus.rdata);
        break;
      end
    end
    check("reissue_seen", got, 1);
    check("sb_drained", sb.size(), 0);

    busm.req_write = 2'b00;
    busm.req_board = 8'h50;
    busm.req_addr = 6'o40;
    busm.Data_In_Port = 8'hC3;
    busm.req_valid = 2'b10;
    push_exp(1, 1'b1, 8'hC3);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clock);
      check("min_ready", busm.req_ready,
            (k == 1) ? 2'b10 : 2'b00);
      if (k == 1) busm.req_valid = '0;
      check("min_rdp", busm.RdP, 32'(k != 2));
      check("min_wrp", busm.WrP, 1);
      check("min_busy", busm.busy, 32'(k <= 3));
      if (k == 3)
        pop_done(busm.req_done, busm.rdata);
      else
        check("min_done_quiet", busm.req_done, 2'b00);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/lamp_bus_arbiter.md
# lamp_bus_arbiter

Shares the lamp-card parallel bus between two requesters: port 0, the UART command path, and port 1, a background ADC/status poller. The block sequences each accepted request as one timed bus cycle (setup, strobe, hold) on the board-select, address, data and read/write strobe pins. It returns read data and a completion pulse to the winning requester. It sits between the top-level command state machine and the pad-level tristate assignment of the data port.

## Interface
- CLOCK_FREQUENCY, 27000000: system clock in Hz; documentation only, no logic derived from it.
- SETUP_CYCLES, 3: cycles that board, address and write data are driven before the strobe; 0 is treated as 1.
- STROBE_CYCLES, 6: cycles the strobe is asserted; 0 is treated as 1.
- HOLD_CYCLES, 3: cycles after strobe release before the bus is freed; 0 is treated as 1.

- clock  in  1  system clock; all logic on its rising edge.
- reset_n  in  1  reset, asynchronous assert, active-low.
- req_valid  in  2  bit i: requester i has a transaction pending; held until req_ready[i].
- req_write  in  2  bit i: 1 = write, 0 = read.
- req_board  in  8  [4i+3:4i] board select for requester i.
- req_addr  in  6  [3i+2:3i] register address for requester i.
- req_wdata  in  16  [8i+7:8i] write data for requester i.
- req_ready  out  2  one-cycle acceptance pulse; fields are latched.
- req_done  out  2  one-cycle completion pulse to the owner.
- rdata  out  8  read data; valid in the req_done cycle, held until the next read completes.
- BOARD_X  out  4  board select to the bus.
- AddessPortPin  out  3  address to the bus.
- Data_Out_Port  out  8  write data to the pad tristate.
- Data_In_Port  in  8  pad data input.
- data_dir  out  1  1 = drive Data_Out_Port onto the pins.
- RdP  out  1  read strobe, active-low.
- WrP  out  1  write strobe, active-low.
- busy  out  1  high in any state other than IDLE.

## Operation
- States: IDLE, SETUP, STROBE, HOLD. A single down-counter is sized for the largest of the three parameters.
- IDLE: if any req_valid bit is set, arbitrate and latch the winner's fields and owner index, pulse that requester's req_ready, load the counter with SETUP_CYCLES, and go to SETUP.
- Arbitration is round-robin. If only one bit is set, that requester wins. If both are set, the requester that was not last granted wins. last_grant resets to 1, so port 0 wins the first tie.
- SETUP: drive BOARD_X and AddessPortPin from the latched fields. For a write, also drive Data_Out_Port and set data_dir=1. When the counter expires, go to STROBE and load STROBE_CYCLES.
- STROBE: drive WrP=0 for a write or RdP=0 for a read. For a read, register Data_In_Port into rdata on the last STROBE cycle. When the counter expires, go to HOLD and load HOLD_CYCLES.
- HOLD: both strobes high; address, board and data_dir are unchanged. When the counter expires, pulse req_done[owner], return to IDLE, and set data_dir=0.
- Latched fields are independent of the inputs: changes to req_* during a transaction have no effect.
- A req_valid that is still set in the req_ready cycle is not a new request. It is the requester's job to drop it.
- Reset values: RdP=1, WrP=1, data_dir=0, BOARD_X=0, AddessPortPin=0, Data_Out_Port=0, rdata=0, req_ready=0, req_done=0, busy=0, state IDLE.
- Reset mid-transaction: strobes go high and data_dir goes low immediately (asynchronously). No req_done is issued. After release, a still-asserted req_valid is arbitrated again as a new request.

## Timing
- Every output is registered.
- Request sampled in IDLE at cycle T:
  - req_ready and first SETUP cycle at T+1.
  - Strobe low from T+1+S through T+S+W.
  - req_done at T+S+W+H, which is the last HOLD cycle.
  - IDLE at T+S+W+H+1; the next grant's req_ready is at T+S+W+H+2 at the earliest.
- Back-to-back transaction period: S+W+H+1 cycles.
- Data_In_Port must be stable at the rising edge that ends the strobe. No input synchroniser is used; the bus is source-synchronous to clock via the strobes.
- RdP and WrP are never both low. data_dir is never 1 while RdP is low.

## Configuration
- LAMP_BUS_FIXED_PRIORITY_EN:
  - Defined: requester 0 always wins when both req_valid bits are set, and last_grant is not implemented.
  - Undefined (default): round-robin as described in Operation.

## Test plan
Defaults S=3, W=6, H=3.
- Reset, then a single write from port 0 (board 4'h2, addr 3'h5, data 8'hA5) with valid at T -> req_ready[0] at T+1; WrP low for cycles T+4..T+9; data_dir high T+1..T+12; req_done[0] at T+12; RdP stays 1.
- Single read from port 1 with Data_In_Port=8'h3C during the strobe -> RdP low T+4..T+9; rdata=8'h3C and req_done[1] at T+12; data_dir stays 0.
- Both ports valid in the same IDLE cycle, held continuously -> grants alternate 0,1,0,1 with a 13-cycle period; with LAMP_BUS_FIXED_PRIORITY_EN defined, port 0 wins every grant.
- req_wdata and req_addr change during STROBE -> bus pins keep the latched values through HOLD.
- reset_n pulled low at T+6 during a write -> WrP=1 and data_dir=0 before the next edge; no req_done; after release with valid still high, req_ready is reissued.
- Parameters S=0, W=0, H=0 -> behaves as 1,1,1; req_done at T+3.
